// File: rtl/alu_result_capture.sv
// Consumer end of the ALU output: captures HI/LO for multiply/divide, queues register
// writebacks in a small FIFO and holds the last accepted flags plus a sticky overflow bit.
module alu_result_capture #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       FS,
    input  logic [31:0]      Y_hi,
    input  logic [31:0]      Y_lo,
    input  logic             N,
    input  logic             Z,
    input  logic             V,
    input  logic             C,
    input  logic [1:0]       in_sel,
    input  logic             in_wr,
    input  logic [4:0]       in_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       out_rd,
    output logic [31:0]      out_data,
    output logic [31:0]      HI,
    output logic [31:0]      LO,
    output logic             N_q,
    output logic             Z_q,
    output logic             V_q,
    output logic             C_q,
    output logic             V_sticky,
    input  logic             clr_sticky,
    output logic [PTR_W:0]   count
);

    localparam logic [4:0]     FsMul = 5'h1E;
    localparam logic [4:0]     FsDiv = 5'h1F;
    localparam logic [PTR_W:0] Full  = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [4:0]       mem_rd   [DEPTH];
    logic [31:0]      mem_data [DEPTH];

    logic        accept, is_hilo, push, pop;
    logic [31:0] wb_data;

    assign in_ready  = (count != Full);
    assign out_valid = (count != '0);
    assign accept    = in_valid & in_ready;
    assign is_hilo   = (FS == FsMul) || (FS == FsDiv);
    assign push      = accept & ~is_hilo & in_wr & (in_rd != 5'd0);
    assign pop       = out_valid & out_ready;

    // Head is masked so the outputs read zero whenever the queue is empty.
    assign out_rd   = out_valid ? mem_rd[rd_ptr]   : 5'd0;
    assign out_data = out_valid ? mem_data[rd_ptr] : 32'd0;

    always_comb begin
        wb_data = Y_lo;
        unique case (in_sel)
            2'b01:   wb_data = HI;
            2'b10:   wb_data = LO;
            default: wb_data = Y_lo;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_rd[wr_ptr]   <= in_rd;
            mem_data[wr_ptr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            HI       <= '0;
            LO       <= '0;
            N_q      <= 1'b0;
            Z_q      <= 1'b0;
            V_q      <= 1'b0;
            C_q      <= 1'b0;
            V_sticky <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (accept) begin
                N_q <= N;
                Z_q <= Z;
                V_q <= V;
                C_q <= C;
                if (is_hilo) begin
                    HI <= Y_hi;
                    LO <= Y_lo;
                end
            end
            // A newly accepted overflow takes priority over a clear in the same cycle.
            if (accept && V)     V_sticky <= 1'b1;
            else if (clr_sticky) V_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_result_capture.sv
// Directed self-checking bench for alu_result_capture with hand-computed expectations.
module tb_alu_result_capture;

    logic        clk, reset;
    logic        in_valid, in_ready;
    logic [4:0]  FS;
    logic [31:0] Y_hi, Y_lo;
    logic        N, Z, V, C;
    logic [1:0]  in_sel;
    logic        in_wr;
    logic [4:0]  in_rd;
    logic        out_valid, out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_data, HI, LO;
    logic        N_q, Z_q, V_q, C_q, V_sticky, clr_sticky;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    alu_result_capture #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .FS(FS), .Y_hi(Y_hi), .Y_lo(Y_lo), .N(N), .Z(Z), .V(V), .C(C),
        .in_sel(in_sel), .in_wr(in_wr), .in_rd(in_rd),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data),
        .HI(HI), .LO(LO), .N_q(N_q), .Z_q(Z_q), .V_q(V_q), .C_q(C_q),
        .V_sticky(V_sticky), .clr_sticky(clr_sticky), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; FS = 5'd0; Y_hi = '0; Y_lo = '0;
        N = 1'b0; Z = 1'b0; V = 1'b0; C = 1'b0;
        in_sel = 2'b00; in_wr = 1'b0; in_rd = 5'd0; clr_sticky = 1'b0;
    endtask

    // One accepted writeback result with FS=0, then inputs return idle.
    task automatic push_wb(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] ylo);
        in_valid = 1'b1; FS = 5'd0; in_wr = 1'b1; in_rd = rd; in_sel = sel; Y_lo = ylo;
        step();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        out_ready = 1'b0;
        reset = 1'b0;
        #12;
        check("in_ready_in_reset", 32'(in_ready), 32'h1);
        step();
        reset = 1'b1;
        step();

        // Reset state
        check("rst_HI", HI, 32'h0);
        check("rst_LO", LO, 32'h0);
        check("rst_flags", 32'({N_q, Z_q, V_q, C_q, V_sticky}), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);
        check("rst_count", 32'(count), 32'h0);
        check("rst_out", 32'({out_rd, out_data}), 32'h0);

        // Multiply result to HI/LO, then read HI/LO back through the FIFO
        in_valid = 1'b1; FS = 5'h1E; Y_hi = 32'h0000_0001; Y_lo = 32'hFFFF_FFFE;
        in_wr = 1'b1; in_rd = 5'd5; N = 1'b1;
        step();
        idle_inputs();
        check("mul_HI", HI, 32'h0000_0001);
        check("mul_LO", LO, 32'hFFFF_FFFE);
        check("mul_count", 32'(count), 32'h0);
        check("mul_N_q", 32'(N_q), 32'h1);
        push_wb(2'b01, 5'd8, 32'h0000_1111);
        check("mfhi_out_valid", 32'(out_valid), 32'h1);
        check("mfhi_out_rd", 32'(out_rd), 32'd8);
        check("mfhi_out_data", out_data, 32'h0000_0001);
        check("mfhi_N_q", 32'(N_q), 32'h0);
        push_wb(2'b10, 5'd9, 32'h0000_2222);
        push_wb(2'b00, 5'd10, 32'h0000_1234);
        push_wb(2'b11, 5'd11, 32'h0000_5678);
        check("sel_count", 32'(count), 32'd4);
        out_ready = 1'b1;
        begin
            logic [4:0]  rds [4];
            logic [31:0] dts [4];
            rds = '{5'd8, 5'd9, 5'd10, 5'd11};
            dts = '{32'h0000_0001, 32'hFFFF_FFFE, 32'h0000_1234, 32'h0000_5678};
            for (int i = 0; i < 4; i++) begin
                check($sformatf("sel_rd%0d", i), 32'(out_rd), 32'(rds[i]));
                check($sformatf("sel_data%0d", i), out_data, dts[i]);
                step();
            end
        end
        out_ready = 1'b0;
        check("sel_drained", 32'(out_valid), 32'h0);

        // Fill to full, reject a fifth result, drain in order
        for (int i = 0; i < 4; i++) push_wb(2'b00, 5'(i + 1), 32'hA0 + 32'(i));
        check("full_count", 32'(count), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'h0);
        in_valid = 1'b1; in_wr = 1'b1; in_rd = 5'd7; Y_lo = 32'hDEAD; V = 1'b1; N = 1'b1;
        step();
        idle_inputs();
        check("full_reject_count", 32'(count), 32'd4);
        check("full_reject_flags", 32'({N_q, V_q, V_sticky}), 32'h0);
        out_ready = 1'b1;
        check("full_pop_no_ready", 32'(in_ready), 32'h0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("full_rd%0d", i), 32'(out_rd), 32'(i + 1));
            check($sformatf("full_data%0d", i), out_data, 32'hA0 + 32'(i));
            step();
        end
        check("full_drained", 32'(out_valid), 32'h0);
        out_ready = 1'b0;

        // Simultaneous push/pop at occupancy 2
        push_wb(2'b00, 5'd1, 32'h11);
        push_wb(2'b00, 5'd2, 32'h22);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_wr = 1'b1; in_sel = 2'b00; in_rd = 5'(20 + i); Y_lo = 32'hBEEF;
            if (i == 0) check("pp_head_data0", out_data, 32'h11);
            else if (i == 1) check("pp_head_data1", out_data, 32'h22);
            else check($sformatf("pp_head_data%0d", i), out_data, 32'hBEEF);
            check($sformatf("pp_head_rd%0d", i), 32'(out_rd), (i < 2) ? 32'(i + 1) : 32'(18 + i));
            step();
            check($sformatf("pp_count%0d", i), 32'(count), 32'd2);
        end
        idle_inputs();
        check("pp_tail_rd0", 32'(out_rd), 32'd24);
        step();
        check("pp_tail_rd1", 32'(out_rd), 32'd25);
        step();
        check("pp_drained", 32'(out_valid), 32'h0);
        out_ready = 1'b0;

        // Sticky overflow: set beats clear, then clear
        in_valid = 1'b1; V = 1'b1; clr_sticky = 1'b1; Z = 1'b1; C = 1'b1;
        step();
        idle_inputs();
        check("sticky_set_wins", 32'(V_sticky), 32'h1);
        check("sticky_flags", 32'({N_q, Z_q, V_q, C_q}), 32'b0111);
        in_valid = 1'b1; V = 1'b0; clr_sticky = 1'b1;
        step();
        idle_inputs();
        check("sticky_cleared", 32'(V_sticky), 32'h0);
        check("sticky_V_q", 32'(V_q), 32'h0);

        // No-push cases and ignored inputs
        in_valid = 1'b1; in_wr = 1'b1; in_rd = 5'd0; Y_lo = 32'h77;
        step();
        in_wr = 1'b0; in_rd = 5'd5;
        step();
        idle_inputs();
        check("no_push_count", 32'(count), 32'h0);
        FS = 5'h1F; Y_hi = 32'h5555; Y_lo = 32'h6666; V = 1'b1;
        step();
        idle_inputs();
        check("invalid_ignored_HI", HI, 32'h0000_0001);
        check("invalid_ignored_V", 32'({V_q, V_sticky}), 32'h0);

        // Asynchronous reset with three entries queued
        for (int i = 0; i < 3; i++) push_wb(2'b00, 5'(i + 1), 32'hC0 + 32'(i));
        check("pre_reset_count", 32'(count), 32'd3);
        #1 reset = 1'b0;
        #1;
        check("async_count", 32'(count), 32'h0);
        check("async_out_valid", 32'(out_valid), 32'h0);
        check("async_out_data", out_data, 32'h0);
        check("async_HI", HI, 32'h0);
        step();
        reset = 1'b1;
        step();
        check("post_reset_in_ready", 32'(in_ready), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running, expected finished");
        $fatal(1);
    end

endmodule

// File: doc/alu_result_capture.md
Name: alu_result_capture

Overview:
- Consumer end of the ALU output interface; sits between alu_32 and register-file writeback.
- Each accepted ALU result is either committed to the HI/LO pair (FS 5'h1E multiply, 5'h1F divide) or queued as a 32-bit writeback entry in a small FIFO.
- The last accepted N/Z/V/C flags are held in a status register, with a sticky overflow bit.
- Also supplies the HI/LO read path (mfhi/mflo) by selecting the current HI or LO value as writeback data.

Parameters:
DEPTH, 4, writeback FIFO entries; power of two, 2..16
PTR_W, 2, pointer width; must equal log2(DEPTH)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  ALU result presented
in_ready  out  1  block can accept this cycle
FS  in  5  function select that produced the result
Y_hi  in  32  upper ALU result
Y_lo  in  32  lower ALU result
N, Z, V, C  in  1 each  ALU flags
in_sel  in  2  writeback source: 00 Y_lo, 01 HI register, 10 LO register, 11 Y_lo
in_wr  in  1  instruction writes a destination register
in_rd  in  5  destination register number
out_valid  out  1  FIFO head valid
out_ready  in  1  writeback consumes head
out_rd  out  5  head destination register
out_data  out  32  head data
HI  out  32  HI register
LO  out  32  LO register
N_q, Z_q, V_q, C_q  out  1 each  status flags
V_sticky  out  1  sticky overflow
clr_sticky  in  1  clears V_sticky
count  out  PTR_W+1  FIFO occupancy

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, all flag outputs=0, V_sticky=0, count=0, read/write pointers=0, out_valid=0, out_rd=0, out_data=0. Reset mid-transfer drops all queued entries.
- in_ready = (count != DEPTH), combinational from registered count only.
  - There is no pass-through when full; a pop in the same cycle does not raise in_ready.
  - in_ready is 1 during and right after reset.
- Accept = in_valid & in_ready. On accept:
  - N_q/Z_q/V_q/C_q <= N/Z/V/C for every FS.
  - V_sticky <= 1 if V=1.
- FS == 5'h1E or 5'h1F:
  - HI <= Y_hi, LO <= Y_lo.
  - No FIFO push, regardless of in_wr.
- Any other FS with in_wr=1 and in_rd != 0:
  - Push {in_rd, data}. data is Y_lo for in_sel 00/11, HI for 01, LO for 10.
  - HI/LO are the register values before this edge.
- in_wr=0 or in_rd=0: no push; flags still update.
- Pop = out_valid & out_ready; the read pointer advances modulo DEPTH.
- Simultaneous push and pop:
  - Legal whenever count is between 1 and DEPTH-1; count is unchanged.
  - At count=0, a pop cannot occur because out_valid=0.
- Pointers wrap from DEPTH-1 to 0.
- out_valid = (count != 0). out_rd/out_data come from the head entry and are stable while out_valid=1 and out_ready=0.
- Latency:
  - A result accepted at edge k is visible at the FIFO output after edge k, when the FIFO was empty.
  - HI/LO written at edge k are readable via in_sel on the next accept.
- clr_sticky=1 clears V_sticky at the edge. If V=1 is accepted in the same cycle, the set wins (V_sticky=1).
- Inputs with in_valid=0 are ignored completely; no state changes except pop.

Test Plan:
- Reset then idle → HI=LO=0, flags=0, out_valid=0, in_ready=1, count=0.
- Accept FS=5'h1E, Y_hi=32'h0000_0001, Y_lo=32'hFFFF_FFFE, in_wr=1, in_rd=5 → HI=1, LO=FFFF_FFFE next cycle, count stays 0. Next accept with in_sel=01, in_rd=8 → out_rd=8, out_data=32'h0000_0001.
- out_ready=0; accept 4 results with Y_lo=A0..A3, in_rd=1..4 → count=4, in_ready=0. A 5th in_valid is ignored. Raise out_ready → data A0, A1, A2, A3 in order, then out_valid=0.
- Occupancy 2, simultaneous push (Y_lo=32'hBEEF) and pop for 6 cycles → count stays 2, pointers wrap, order preserved.
- Accept V=1 with clr_sticky=1 in the same cycle → V_sticky=1. Then accept V=0 with clr_sticky=1 → V_sticky=0, V_q=0.
- in_rd=0 with in_wr=1 → no push. Assert reset low mid-stream with count=3 → count=0, out_valid=0 immediately, without waiting for a clock.
